// File: rtl/irq_timer_pkg.sv
// irq_timer_pkg: shared definitions for the memory-mapped interval timer.
//   - register word offsets (addr[3:2]) for TH, TL, TCON
//   - TCON bit indices and a packed TCON view
//   - helper to widen TCON to a bus word (upper bits read as zero)
package irq_timer_pkg;

  localparam logic [1:0] OFS_TH   = 2'd0;
  localparam logic [1:0] OFS_TL   = 2'd1;
  localparam logic [1:0] OFS_TCON = 2'd2;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_ST = 2;

  // Field order puts st at bit 2, ie at bit 1, en at bit 0.
  typedef struct packed {
    logic st;
    logic ie;
    logic en;
  } tcon_t;

  function automatic logic [31:0] tcon_word(input tcon_t t);
    return {29'd0, t};
  endfunction

endpackage

// File: rtl/tick_divider.sv
// tick_divider: prescaler producing a one-cycle tick every PRESCALE enabled
// cycles.
//   clk   in  core clock
//   rst_n in  synchronous active-low reset
//   en    in  count enable; while low the count is held at 0
//   clr   in  restart the count from 0 at the next edge
//   tick  out high for the cycle in which count == PRESCALE-1
module tick_divider #(
  parameter int PRESCALE   = 1,
  parameter int PRESCALE_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  // Combinational so the tick lines up with the cycle that reaches LAST.
  assign tick = en & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (!en || clr || tick) cnt_d = '0;
    else                    cnt_d = cnt_q + PRESCALE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/irq_timer.sv
// irq_timer: memory-mapped interval timer on the data-memory bus.
// TL counts up on each prescaler tick; on overflow it reloads from TH and,
// if IE is set, latches the sticky status bit ST. irq is ST & IE, masked
// while the CPU runs in kernel mode.
//   clk    in  core clock
//   rst_n  in  synchronous active-low reset
//   addr   in  byte address (TH at BASE, TL at +4, TCON at +8)
//   wdata  in  store data
//   mem_wr in  store strobe
//   mem_rd in  load strobe
//   rdata  out load data (combinational, 0 unless sel & mem_rd)
//   sel    out address decodes to one of the three registers
//   kernel in  PC[31] of the current instruction
//   irq    out interrupt request
module irq_timer
  import irq_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
  parameter int          PRESCALE   = 1,
  parameter int          PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_wr,
  input  logic        mem_rd,
  output logic [31:0] rdata,
  output logic        sel,
  input  logic        kernel,
  output logic        irq
);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  tcon_t       tcon_q, tcon_d;

  logic [1:0]  ofs;
  logic        wr_th, wr_tl, wr_tcon;
  logic        tick, ovf, div_clr;

  // ---------------------------------------------------------------- decode
  assign ofs     = addr[3:2];
  assign sel     = (addr[31:4] == BASE_ADDR[31:4]) && (ofs != 2'd3);
  assign wr_th   = sel & mem_wr & (ofs == OFS_TH);
  assign wr_tl   = sel & mem_wr & (ofs == OFS_TL);
  assign wr_tcon = sel & mem_wr & (ofs == OFS_TCON);

  // ------------------------------------------------------------- prescaler
  // A TL write restarts the prescale period; clearing EN also restarts it so
  // a later re-enable begins a full period.
  assign div_clr = wr_tl | (wr_tcon & ~wdata[TCON_EN]);

  tick_divider #(
    .PRESCALE  (PRESCALE),
    .PRESCALE_W(PRESCALE_W)
  ) u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (tcon_q.en),
    .clr  (div_clr),
    .tick (tick)
  );

  // A TL write swallows the tick, so it can neither count nor overflow.
  assign ovf = tick & ~wr_tl & (tl_q == 32'hFFFF_FFFF);

  // -------------------------------------------------------- next state
  always_comb begin
    th_d = th_q;
    if (wr_th) th_d = wdata;
  end

  always_comb begin
    tl_d = tl_q;
    if (wr_tl)     tl_d = wdata;
    else if (ovf)  tl_d = th_q;            // old TH even if TH is written now
    else if (tick) tl_d = tl_q + 32'd1;
  end

  // Written ST is ORed with a same-cycle overflow so a clear cannot drop it;
  // the overflow honours the newly written IE.
  always_comb begin
    tcon_d = tcon_q;
    if (wr_tcon) begin
      tcon_d = tcon_t'(wdata[2:0]);
      if (ovf && wdata[TCON_IE]) tcon_d.st = 1'b1;
    end else if (ovf && tcon_q.ie) begin
      tcon_d.st = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  // ------------------------------------------------------------- read port
  always_comb begin
    rdata = '0;
    if (sel && mem_rd) begin
      case (ofs)
        OFS_TH:   rdata = th_q;
        OFS_TL:   rdata = tl_q;
        OFS_TCON: rdata = tcon_word(tcon_q);
        default:  rdata = '0;
      endcase
    end
  end

  assign irq = tcon_q.st & tcon_q.ie & ~kernel;

endmodule

// File: tb/tb_irq_timer.sv
module tb_irq_timer;

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_HOLE = 32'h4000_000C;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr, wdata;
  logic        mem_wr, mem_rd, kernel;
  logic [31:0] rdata1, rdata4;
  logic        sel1, sel4, irq1, irq4;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  irq_timer #(.PRESCALE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .rdata(rdata1), .sel(sel1),
    .kernel(kernel), .irq(irq1)
  );

  irq_timer #(.PRESCALE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .rdata(rdata4), .sel(sel4),
    .kernel(kernel), .irq(irq4)
  );

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    q.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.val) else begin
        n_bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; mem_wr = 1'b1;
    step(1);
    mem_wr = 1'b0; addr = '0; wdata = '0;
  endtask

  // which: 1 -> PRESCALE=1 instance, 4 -> PRESCALE=4 instance
  task automatic rd(input int which, input string tag,
                    input logic [31:0] a, input logic [31:0] e);
    push(tag, e);
    addr = a; mem_rd = 1'b1;
    #1;
    pop_cmp(which == 4 ? rdata4 : rdata1);
    mem_rd = 1'b0; addr = '0;
  endtask

  task automatic chk_irq(input string tag, input logic e);
    push(tag, {31'd0, e});
    #1;
    pop_cmp({31'd0, irq1});
  endtask

  initial begin
    rst_n = 1'b0; addr = '0; wdata = '0;
    mem_wr = 1'b0; mem_rd = 1'b0; kernel = 1'b0;
    step(2);
    rst_n = 1'b1;

    // reset state and decode
    rd(1, "rst_th",   A_TH,   32'h0);
    rd(1, "rst_tl",   A_TL,   32'h0);
    rd(1, "rst_tcon", A_TCON, 32'h0);
    chk_irq("rst_irq", 1'b0);
    push("hole_sel", 32'h0);
    addr = A_HOLE; mem_rd = 1'b1; #1;
    pop_cmp({31'd0, sel1});
    rd(1, "hole_rdata", A_HOLE, 32'h0);
    push("tcon_sel", 32'h1);
    addr = A_TCON; #1;
    pop_cmp({31'd0, sel1});
    addr = '0;

    // overflow with IE=1
    wr(A_TH, 32'hFFFF_FFFC);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 32'h3);
    step(1);
    rd(1, "tl_ff", A_TL, 32'hFFFF_FFFF);
    step(1);
    rd(1, "tl_reload", A_TL, 32'hFFFF_FFFC);
    rd(1, "tcon_st", A_TCON, 32'h7);
    chk_irq("irq_set", 1'b1);
    kernel = 1'b1;
    chk_irq("irq_kernel_mask", 1'b0);
    kernel = 1'b0;
    wr(A_TCON, 32'h3);
    chk_irq("irq_cleared", 1'b0);
    rd(1, "tcon_cleared", A_TCON, 32'h3);

    // overflow with IE=0: reload but no status
    wr(A_TCON, 32'h0);
    wr(A_TH, 32'h5);
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TCON, 32'h1);
    step(1);
    rd(1, "ie0_tl", A_TL, 32'h5);
    rd(1, "ie0_tcon", A_TCON, 32'h1);
    for (int i = 0; i < 3; i++) begin
      chk_irq("ie0_irq", 1'b0);
      step(1);
    end

    // TCON write with ST=0 on the overflow tick keeps ST
    wr(A_TCON, 32'h0);
    wr(A_TH, 32'h20);
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TCON, 32'h3);
    wr(A_TCON, 32'h3);
    rd(1, "conflict_tcon", A_TCON, 32'h7);
    rd(1, "conflict_tl", A_TL, 32'h20);

    // TL write on a tick cycle wins, tick discarded
    wr(A_TL, 32'h10);
    rd(1, "tl_write_wins", A_TL, 32'h10);

    // TH write on the overflow tick: TL takes the old TH
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TH, 32'h99);
    rd(1, "old_th_tl", A_TL, 32'h20);
    rd(1, "new_th", A_TH, 32'h99);

    // reset while irq is high and counting
    chk_irq("pre_rst_irq", 1'b1);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    chk_irq("post_rst_irq", 1'b0);
    rd(1, "post_rst_th",   A_TH,   32'h0);
    rd(1, "post_rst_tl",   A_TL,   32'h0);
    rd(1, "post_rst_tcon", A_TCON, 32'h0);
    step(3);
    rd(1, "post_rst_frozen", A_TL, 32'h0);

    // PRESCALE=4 instance
    wr(A_TL, 32'h0);
    wr(A_TCON, 32'h1);
    step(3);
    rd(4, "p4_tl_3", A_TL, 32'h0);
    step(1);
    rd(4, "p4_tl_4", A_TL, 32'h1);
    step(4);
    rd(4, "p4_tl_8", A_TL, 32'h2);
    step(1);
    wr(A_TCON, 32'h0);
    step(6);
    rd(4, "p4_hold", A_TL, 32'h2);
    wr(A_TCON, 32'h1);
    step(3);
    rd(4, "p4_reen_3", A_TL, 32'h2);
    step(1);
    rd(4, "p4_reen_4", A_TL, 32'h3);

    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
